// File: rtl/sync_debounce_edge_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce_edge_if
// Description : Bundles the level inputs, the event clear strobe and the
//               debounced level / edge / event outputs of sync_debounce_edge.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_debounce_edge_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] d_sync_i;
  logic [DATA_WIDTH-1:0] clr_i;
  logic [DATA_WIDTH-1:0] level_o;
  logic [DATA_WIDTH-1:0] rise_o;
  logic [DATA_WIDTH-1:0] fall_o;
  logic [DATA_WIDTH-1:0] event_o;
  logic                  any_event_o;

  // Producer of the level inputs / consumer of the debounced results
  modport master (
    output d_sync_i, clr_i,
    input  level_o, rise_o, fall_o, event_o, any_event_o
  );

  // The debouncer itself
  modport slave (
    input  d_sync_i, clr_i,
    output level_o, rise_o, fall_o, event_o, any_event_o
  );
endinterface
`default_nettype wire

// File: rtl/sync_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce_edge
// Description : Per-bit consecutive-sample debouncer for already-synchronized
//               level inputs. Emits one-cycle rise/fall pulses and sticky
//               write-1-to-clear event flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce_edge #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DEBOUNCE_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  wire logic            clk,
  input  wire logic            resetn,
  sync_debounce_edge_if.slave  bus
);

  localparam int                 CW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]      C_CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d;
  logic [DATA_WIDTH-1:0] fall_q, fall_d;
  logic [DATA_WIDTH-1:0] event_q, event_d;
  logic [DATA_WIDTH-1:0] accept_w;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_w;

    // Count consecutive samples that disagree with the debounced level;
    // any agreeing sample restarts the count, the final one accepts.
    always_comb begin
      cnt_d = cnt_q;
      acc_w = 1'b0;
      if (bus.d_sync_i[b] != level_q[b]) begin
        if (cnt_q == C_CNT_MAX) begin
          acc_w = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end

    // Per-bit sample counter
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign accept_w[b] = acc_w;
  end

  // Apply accepted changes; the pulse polarity follows the new level and a
  // fresh edge outranks a simultaneous software clear of its event flag.
  always_comb begin
    level_d = (level_q & ~accept_w) | (bus.d_sync_i & accept_w);
    rise_d  = accept_w & bus.d_sync_i;
    fall_d  = accept_w & ~bus.d_sync_i;
    event_d = (event_q & ~bus.clr_i) | accept_w;
  end

  // Output / status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= RESET_LEVEL;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign bus.level_o     = level_q;
  assign bus.rise_o      = rise_q;
  assign bus.fall_o      = fall_q;
  assign bus.event_o     = event_q;
  assign bus.any_event_o = |event_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_debounce_edge
// Description : Self-checking bench. Two instances (4-sample and 1-sample
//               debounce) see identical stimulus; a history-based reference
//               model checks both every cycle, a vector table checks the
//               4-sample instance against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_debounce_edge;

  localparam int W = 4;

  logic clk;
  logic resetn;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sync_debounce_edge_if #(.DATA_WIDTH(W)) bus_a ();
  sync_debounce_edge_if #(.DATA_WIDTH(W)) bus_b ();

  sync_debounce_edge #(.DATA_WIDTH(W), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(4'b0000)) u_dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  sync_debounce_edge #(.DATA_WIDTH(W), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(4'b0000)) u_dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Keeps every sample since reset; a bit changes once the most recent
  // run of samples that disagree with its level (counted only since the
  // last acceptance) reaches the debounce length.
  logic [W-1:0] hist[$];
  int           dc[2]      = '{4, 1};
  int           since[2][W];
  logic [W-1:0] m_lvl[2];
  logic [W-1:0] m_rise[2];
  logic [W-1:0] m_fall[2];
  logic [W-1:0] m_evt[2];

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < W; b++) since[m][b] = 0;
      m_lvl[m]  = 4'b0000;
      m_rise[m] = '0;
      m_fall[m] = '0;
      m_evt[m]  = '0;
    end
  endtask

  task automatic model_edge(input logic [W-1:0] d, input logic [W-1:0] clr);
    logic [W-1:0] acc;
    logic [W-1:0] s;
    int           streak;
    hist.push_back(d);
    for (int m = 0; m < 2; m++) begin
      acc = '0;
      for (int b = 0; b < W; b++) begin
        streak = 0;
        for (int i = hist.size() - 1; i >= since[m][b]; i--) begin
          s = hist[i];
          if (s[b] != m_lvl[m][b]) streak++;
          else break;
        end
        if (streak >= dc[m]) begin
          acc[b]      = 1'b1;
          since[m][b] = hist.size();
        end
      end
      m_lvl[m]  = (m_lvl[m] & ~acc) | (d & acc);
      m_rise[m] = acc & d;
      m_fall[m] = acc & ~d;
      m_evt[m]  = (m_evt[m] & ~clr) | acc;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("A.level", bus_a.level_o, m_lvl[0]);
    chk("A.rise",  bus_a.rise_o,  m_rise[0]);
    chk("A.fall",  bus_a.fall_o,  m_fall[0]);
    chk("A.event", bus_a.event_o, m_evt[0]);
    chk("A.any",   {3'b000, bus_a.any_event_o}, {3'b000, |m_evt[0]});
    chk("B.level", bus_b.level_o, m_lvl[1]);
    chk("B.rise",  bus_b.rise_o,  m_rise[1]);
    chk("B.fall",  bus_b.fall_o,  m_fall[1]);
    chk("B.event", bus_b.event_o, m_evt[1]);
    chk("B.any",   {3'b000, bus_b.any_event_o}, {3'b000, |m_evt[1]});
  endtask

  // Drive inputs away from the edge, clock once, then compare 1 ns later.
  task automatic step(input logic [W-1:0] d, input logic [W-1:0] clr);
    bus_a.d_sync_i = d;  bus_a.clr_i = clr;
    bus_b.d_sync_i = d;  bus_b.clr_i = clr;
    @(posedge clk);
    cyc++;
    model_edge(d, clr);
    #1;
    chk_model();
  endtask

  // Asynchronous reset pulse, asserted and released between clock edges.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(posedge clk);
    #1;
    chk_model();
    resetn = 1'b1;
  endtask

  // ---------------- directed vectors (4-sample instance) ----------------
  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] clr;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] evt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [W-1:0] d, input logic [W-1:0] clr, input logic [W-1:0] lvl,
                     input logic [W-1:0] rise, input logic [W-1:0] fall, input logic [W-1:0] evt);
    vec_t v;
    v.d = d; v.clr = clr; v.lvl = lvl; v.rise = rise; v.fall = fall; v.evt = evt;
    tbl.push_back(v);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] clr;

    // bit0 rises after the 4th sample
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    // bit0 falls and bit2 rises together
    add(4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0101);
    // clear bit0 event, then clear bit2 on the cycle bit2 re-fires
    add(4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    add(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // glitches: 3 high / 1 low, then 3 high / 1 low / 3 high / 1 low
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Power-on reset
    resetn = 1'b0;
    bus_a.d_sync_i = '0; bus_a.clr_i = '0;
    bus_b.d_sync_i = '0; bus_b.clr_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.A.level", bus_a.level_o, 4'b0000);
    chk("rst.A.event", bus_a.event_o, 4'b0000);
    chk("rst.A.any",   {3'b000, bus_a.any_event_o}, 4'b0000);
    chk_model();
    resetn = 1'b1;

    // Table-driven sequence
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].d, tbl[i].clr);
      chk($sformatf("vec%0d.level", i), bus_a.level_o, tbl[i].lvl);
      chk($sformatf("vec%0d.rise",  i), bus_a.rise_o,  tbl[i].rise);
      chk($sformatf("vec%0d.fall",  i), bus_a.fall_o,  tbl[i].fall);
      chk($sformatf("vec%0d.event", i), bus_a.event_o, tbl[i].evt);
      chk($sformatf("vec%0d.any",   i), {3'b000, bus_a.any_event_o}, {3'b000, |tbl[i].evt});
    end

    // Reset in the middle of a bit3 count, released with bit3 still high
    step(4'b1000, 4'b0000);
    step(4'b1000, 4'b0000);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("midrst.A.level", bus_a.level_o, 4'b0000);
    chk("midrst.B.level", bus_b.level_o, 4'b0000);
    chk("midrst.B.event", bus_b.event_o, 4'b0000);
    chk_model();
    resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(4'b1000, 4'b0000);
      chk($sformatf("postrst%0d.A.rise", i), bus_a.rise_o, (i == 4) ? 4'b1000 : 4'b0000);
    end
    step(4'b1000, 4'b0000);
    chk("postrst5.A.rise", bus_a.rise_o, 4'b0000);

    // Single-sample instance: bit1 toggling every cycle is followed one edge late
    for (int i = 0; i < 8; i++) begin
      d = (i % 2 == 0) ? 4'b1010 : 4'b1000;
      step(d, 4'b0000);
      chk($sformatf("tog%0d.B.level", i), bus_b.level_o, d);
      chk($sformatf("tog%0d.B.rise",  i), bus_b.rise_o,  (i % 2 == 0) ? 4'b0010 : 4'b0000);
      chk($sformatf("tog%0d.B.fall",  i), bus_b.fall_o,  (i % 2 == 0) ? 4'b0000 : 4'b0010);
      chk($sformatf("tog%0d.B.excl",  i), bus_b.rise_o & bus_b.fall_o, 4'b0000);
    end

    // Randomized traffic with occasional asynchronous resets
    d = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
      end
      clr = '0;
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 7) == 0) clr[b] = 1'b1;
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      step(d, clr);
      chk("rand.A.excl", bus_a.rise_o & bus_a.fall_o, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Downstream consumer of the two-stage domain synchronizer.
- Takes already-synchronized multi-bit level inputs and debounces each bit independently with a consecutive-sample counter.
- Produces single-cycle rise/fall pulses per bit, plus sticky per-bit event flags that are cleared by software.
- Sits between pad/CDC synchronization and control logic: GPIO, buttons, status lines.

Parameters:
- DATA_WIDTH, 32, number of independent bits processed.
- DEBOUNCE_CYCLES, 4, consecutive differing samples required to accept a change; legal range >= 1.
- RESET_LEVEL, 0, DATA_WIDTH-bit reset value of the debounced level register.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- resetn  input  1  asynchronous active-low reset.
- d_sync_i  input  DATA_WIDTH  synchronized level inputs; the block adds no further synchronization.
- clr_i  input  DATA_WIDTH  write-1-to-clear mask for event_o; single-cycle strobe.
- level_o  output  DATA_WIDTH  debounced level.
- rise_o  output  DATA_WIDTH  1-cycle pulse when a bit of level_o goes 0->1.
- fall_o  output  DATA_WIDTH  1-cycle pulse when a bit of level_o goes 1->0.
- event_o  output  DATA_WIDTH  sticky flag, set on any accepted edge.
- any_event_o  output  1  reduction OR of event_o, registered-derived (combinational from event_o).

Behaviour:
- Clock and reset: one clock, `clk`; reset `resetn` is asynchronous, active-low.
- Reset values:
  - level_o = RESET_LEVEL.
  - rise_o, fall_o, event_o = 0; any_event_o = 0.
  - All counters = 0.
- Counter:
  - One counter per bit, width $clog2(DEBOUNCE_CYCLES+1), saturating never needed.
  - Each edge where d_sync_i[b] != level_o[b] and cnt[b] < DEBOUNCE_CYCLES-1: cnt[b] += 1.
  - Each edge where d_sync_i[b] == level_o[b]: cnt[b] <= 0 (glitch rejection; any matching sample restarts the count).
- Acceptance:
  - Condition: d_sync_i[b] != level_o[b] and cnt[b] == DEBOUNCE_CYCLES-1, at an edge.
  - At that edge: level_o[b] <= d_sync_i[b] and cnt[b] <= 0.
  - At the same edge: rise_o[b] <= d_sync_i[b] and fall_o[b] <= ~d_sync_i[b]; otherwise both are 0 next cycle.
- Latency: with d_sync_i stable at the new value from edge k onward, level_o changes and the pulse is asserted after edge k+DEBOUNCE_CYCLES-1. DEBOUNCE_CYCLES=1 gives a 1-cycle registered follow.
- Pulse properties:
  - rise_o[b] and fall_o[b] are never both high.
  - A pulse is high for exactly one cycle.
  - Back-to-back edges on one bit are at least DEBOUNCE_CYCLES cycles apart.
- event_o[b]:
  - Next value = (event_o[b] & ~clr_i[b]) | accepted_edge[b].
  - Set wins over a simultaneous clear.
  - clr_i on a bit with no event has no effect.
- Bit independence: bits never interact. Simultaneous changes on multiple bits are counted and accepted independently.
- Reset mid-count: an in-progress count is discarded and level_o returns to RESET_LEVEL. If an input differs from RESET_LEVEL after reset release, it requires a full DEBOUNCE_CYCLES samples and then produces an edge pulse.
- Input equal to RESET_LEVEL after reset: no pulse is generated.
- X on d_sync_i is not expected; no special handling.

Test Plan:
1. DATA_WIDTH=4, DEBOUNCE_CYCLES=4, RESET_LEVEL=0. Drive d_sync_i 0000->0001 and hold → level_o=0001 and rise_o=0001 for exactly one cycle, after the 4th edge sampling 1; event_o=0001; any_event_o=1.
2. Glitch: d_sync_i[0]=1 for 3 cycles, then 0 → no change in level_o, no pulse, cnt[0] returns to 0. Repeat with 3-high/1-low/3-high → still no acceptance.
3. From level_o=0001, drop bit0 and raise bit2 on the same cycle and hold → after 4 edges, level_o=0100, fall_o=0001 and rise_o=0100 in the same cycle, event_o=0101.
4. clr_i=0001 with event_o=0101 → event_o=0100. Then clr_i=0100 asserted in the same cycle as a new accepted edge on bit2 → event_o[2] stays 1.
5. Assert resetn low after 2 counted samples of bit3 → all outputs 0 asynchronously. Release with d_sync_i[3]=1 held → rise_o=1000 after 4 edges post-release.
6. DEBOUNCE_CYCLES=1: toggle d_sync_i[1] every cycle → level_o[1] follows with 1-cycle delay; rise_o[1] and fall_o[1] alternate each cycle and are never simultaneous.
